mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the pipelined CPU. The block runs a registered request/done handshake toward each requester and a hold-until-ready handshake toward memory. Data accesses have priority. A starvation counter guarantees that fetch progresses. The requesters' `done` pulses feed the CPU stall logic: a stage waits while its request is pending and not yet done.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch is waiting; range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 resets all state immediately.
- `fetchReq` in 1: fetch wants a word read at `fetchAddr`.
- `fetchAddr` in 32: word address; bits [1:0] are ignored and driven as 0 to memory.
- `fetchDone` out 1: one-cycle pulse; `fetchData` is valid in the same cycle.
- `fetchData` out 32: last fetched word.
- `dataReq` in 1: data port request.
- `dataWrite` in 1: 1 = store, 0 = load.
- `dataByteEnable` in 4: byte lanes for stores; forced to 4'b1111 for loads.
- `dataAddr` in 32: byte address; passed to memory unchanged.
- `dataWriteData` in 32: store data.
- `dataDone` out 1: one-cycle completion pulse, for loads and stores.
- `dataReadData` out 32: last loaded word.
- `memReq` out 1: memory request.
- `memWrite` out 1: memory write strobe.
- `memByteEnable` out 4: memory byte lanes.
- `memAddr` out 32: memory address.
- `memWriteData` out 32: memory write data.
- `memReady` in 1: the memory completes the request in any cycle where `memReq` and `memReady` are both 1.
- `memReadData` in 32: read data, valid in the completing cycle.

## Operation
- **FSM states:** IDLE, FETCH, DATA, DONE.
- **IDLE:**
  - No request: stay in IDLE.
  - Otherwise, pick a winner:
    - fetch if `fetchReq` && (!`dataReq` || `starveCnt` == STARVE_LIMIT);
    - else data.
  - Latch the winner's address, write flag, byte enables and write data into the mem* output registers.
  - Set `memReq`=1 and go to FETCH or DATA.
- **FETCH / DATA:**
  - Hold `memReq` and all mem* outputs stable until `memReady`=1.
  - On completion:
    - `memReq` returns to 0.
    - For a fetch, or a data load, capture `memReadData` into `fetchData` or `dataReadData`.
    - A store leaves `dataReadData` unchanged.
    - Pulse the matching done output in the DONE cycle.
- **DONE:**
  - The done pulse is high for exactly this cycle.
  - No arbitration happens in DONE; the requester updates or drops its request in this cycle.
  - Next state is IDLE.
- **Starvation counter `starveCnt`, 4 bits:**
  - Increments on each data grant made while `fetchReq`=1.
  - Clears on any fetch grant, and in any IDLE cycle where `fetchReq`=0.
  - Saturates at STARVE_LIMIT.
- **Requester rules:**
  - A requester holds its request and fields stable from assertion until it sees its done pulse.
  - If a requester drops its request early, the transaction already in flight still completes and pulses done; that done is ignored.
  - Request fields are sampled only in IDLE.
- **Reset:**
  - Outputs, state and counter go to 0/IDLE asynchronously.
  - An in-flight memory transaction is abandoned: `memReq` falls immediately and no done is issued.
  - Release of reset is synchronized by the surrounding design.

## Timing
- **Reset values:**
  - `memReq`, `memWrite`, `fetchDone`, `dataDone` = 0.
  - `memByteEnable`, `memAddr`, `memWriteData`, `fetchData`, `dataReadData` = 0.
  - State IDLE, `starveCnt` 0.
- **Minimum latency, zero-wait memory:**
  - Request seen in IDLE at cycle 0.
  - `memReq`=1 in cycle 1; `memReady`=1 in cycle 1.
  - Done in cycle 2; next arbitration in cycle 3.
- **Throughput:** at most one access per 3 cycles. Each memory wait cycle adds 1 cycle of latency.
- **All outputs are registered;** there is no combinational path from inputs to outputs.
- **Simultaneous events:**
  - `fetchReq` and `dataReq` both rising in the same IDLE cycle: data wins unless the starvation rule applies.
  - A request asserted during FETCH, DATA or DONE is considered only at the next IDLE.

## Test plan
- **Single fetch.** After reset, `fetchReq`=1 with `fetchAddr`=0x00003007, and `memReady` tied to 1 returning 0x24080005. Required: `memAddr`=0x00003004 in cycle 1, `fetchDone`=1 with `fetchData`=0x24080005 in cycle 2, and no `dataDone`.
- **Store with waits.** `dataReq`=1, `dataWrite`=1, `dataByteEnable`=4'b0011, `dataAddr`=0x10, `dataWriteData`=0xDEADBEEF; `memReady` low for 3 cycles. Required: mem* fields held stable for 4 cycles with `memWrite`=1 and byte enables 0011, then `dataDone` 1 cycle later, and `dataReadData` unchanged.
- **Priority.** Both ports request in the same cycle. Required: data served first, then fetch on the next IDLE.
- **Starvation.** STARVE_LIMIT=4; `dataReq` held high with back-to-back loads while `fetchReq` stays high. Required: grant order D, D, D, D, F, D, …
- **Reset mid-transaction.** Pull `reset` low while in DATA with `memReady`=0. Required: `memReq` is 0 in the same cycle, no `dataDone` ever appears, and after release a new fetch completes normally.
- **Early drop.** `fetchReq` deasserted in cycle 1 of a fetch. Required: `memReq` is still held until `memReady`, `fetchDone` still pulses, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory handshake signals of the memory port arbiter
interface mem_port_arbiter_if;
  logic fetchReq;
  logic [31:0] fetchAddr;
  logic fetchDone;
  logic [31:0] fetchData;
  logic dataReq;
  logic dataWrite;
  logic [3:0] dataByteEnable;
  logic [31:0] dataAddr;
  logic [31:0] dataWriteData;
  logic dataDone;
  logic [31:0] dataReadData;
  logic memReq;
  logic memWrite;
  logic [3:0] memByteEnable;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic memReady;
  logic [31:0] memReadData;
  modport master (
    output fetchReq, fetchAddr, dataReq, dataWrite, dataByteEnable, dataAddr, dataWriteData, memReady, memReadData,
    input fetchDone, fetchData, dataDone, dataReadData, memReq, memWrite, memByteEnable, memAddr, memWriteData
  );
  modport slave (
    input fetchReq, fetchAddr, dataReq, dataWrite, dataByteEnable, dataAddr, dataWriteData, memReady, memReadData,
    output fetchDone, fetchData, dataDone, dataReadData, memReq, memWrite, memByteEnable, memAddr, memWriteData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports, data first with a fetch starvation guard
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic any_req, grant_fetch, complete;
  // arbitration decision and next state; fetch wins only when data is absent or fetch has waited long enough
  always_comb begin
    any_req = bus.fetchReq || bus.dataReq;
    grant_fetch = bus.fetchReq && (!bus.dataReq || starve_cnt == 4'(STARVE_LIMIT));
    complete = (state == FETCH || state == DATA) && bus.memReady;
    state_nxt = state == IDLE ? (!any_req ? IDLE : grant_fetch ? FETCH : DATA) :
                state == DONE ? IDLE : complete ? DONE : state;
  end
  // state register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // registered memory request, completion pulses, read data capture and starvation count
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      starve_cnt <= '0;
      bus.memReq <= 1'b0;
      bus.memWrite <= 1'b0;
      bus.memByteEnable <= '0;
      bus.memAddr <= '0;
      bus.memWriteData <= '0;
      bus.fetchDone <= 1'b0;
      bus.dataDone <= 1'b0;
      bus.fetchData <= '0;
      bus.dataReadData <= '0;
    end else begin
      bus.fetchDone <= complete && state == FETCH;
      bus.dataDone <= complete && state == DATA;
      if (state == IDLE)
        starve_cnt <= (!bus.fetchReq || grant_fetch) ? '0 : starve_cnt + 4'd1;
      if (state == IDLE && any_req) begin
        bus.memReq <= 1'b1;
        bus.memWrite <= !grant_fetch && bus.dataWrite;
        bus.memByteEnable <= (grant_fetch || !bus.dataWrite) ? 4'hf : bus.dataByteEnable;
        bus.memAddr <= grant_fetch ? {bus.fetchAddr[31:2], 2'b00} : bus.dataAddr;
        bus.memWriteData <= grant_fetch ? '0 : bus.dataWriteData;
      end
      if (complete) bus.memReq <= 1'b0;
      if (complete && state == FETCH) bus.fetchData <= bus.memReadData;
      if (complete && state == DATA && !bus.memWrite) bus.dataReadData <= bus.memReadData;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner-case sequences and randomized traffic against a cycle-count reference model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit fetch;
    bit wr;
    logic [3:0] be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int waits;
    logic [31:0] e_addr;
    logic [3:0] e_be;
    bit e_wr;
    logic [31:0] e_fdata;
    logic [31:0] e_ddata;
  } vec_t;
  vec_t vecs[5];

  bit active, done_fetch, m_fetch, m_wr, gf, exp_req, ok, seen;
  logic [31:0] m_addr, m_wdata, m_fdata, m_ddata;
  logic [3:0] m_be;
  int grant_cyc, done_at, next_arb, starve;
  string order;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.fetchReq = 1'b0;
    bus.fetchAddr = '0;
    bus.dataReq = 1'b0;
    bus.dataWrite = 1'b0;
    bus.dataByteEnable = '0;
    bus.dataAddr = '0;
    bus.dataWriteData = '0;
    bus.memReady = 1'b0;
    bus.memReadData = '0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++)
      if (bus.memReq) got = 1'b1;
      else tick();
  endtask

  task automatic run_vec(input vec_t v);
    bus.fetchReq = v.fetch;
    bus.fetchAddr = v.addr;
    bus.dataReq = !v.fetch;
    bus.dataWrite = v.wr;
    bus.dataByteEnable = v.be;
    bus.dataAddr = v.addr;
    bus.dataWriteData = v.wdata;
    bus.memReady = 1'b0;
    bus.memReadData = ~v.rdata;
    tick();
    for (int w = 0; w <= v.waits; w++) begin
      check("vec mem fields", 64'({bus.memReq, bus.memWrite, bus.memByteEnable, bus.memAddr}),
            64'({1'b1, v.e_wr, v.e_be, v.e_addr}));
      if (v.e_wr) check("vec mem wdata", 64'(bus.memWriteData), 64'(v.wdata));
      check("vec done too early", 64'({bus.fetchDone, bus.dataDone}), 64'(0));
      if (w == v.waits) begin
        bus.memReady = 1'b1;
        bus.memReadData = v.rdata;
      end
      tick();
    end
    check("vec done pulse", 64'({bus.memReq, bus.fetchDone, bus.dataDone}), 64'({1'b0, v.fetch, !v.fetch}));
    check("vec fetchData", 64'(bus.fetchData), 64'(v.e_fdata));
    check("vec dataReadData", 64'(bus.dataReadData), 64'(v.e_ddata));
    quiet();
    tick();
    check("vec done one cycle", 64'({bus.memReq, bus.fetchDone, bus.dataDone}), 64'(0));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h0000_3007, 32'h0, 32'h2408_0005, 0, 32'h0000_3004, 4'hf, 1'b0, 32'h2408_0005, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 3, 32'h0000_0010, 4'h3, 1'b1, 32'h2408_0005, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 4'h3, 32'h0000_0020, 32'h5555_5555, 32'hCAFE_F00D, 1, 32'h0000_0020, 4'hf, 1'b0, 32'h2408_0005, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_0013, 2, 32'hFFFF_FFFC, 4'hf, 1'b0, 32'h0000_0013, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 4'h8, 32'h0000_0103, 32'h1234_5678, 32'h9999_9999, 0, 32'h0000_0103, 4'h8, 1'b1, 32'h0000_0013, 32'hCAFE_F00D};
    quiet();
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", 64'({bus.memReq, bus.memWrite, bus.fetchDone, bus.dataDone, bus.memByteEnable}), 64'(0));
    check("reset memAddr", 64'(bus.memAddr), 64'(0));
    check("reset memWriteData", 64'(bus.memWriteData), 64'(0));
    check("reset read data", 64'({bus.fetchData, bus.dataReadData}), 64'(0));
    reset = 1'b1;
    tick();
    foreach (vecs[i]) run_vec(vecs[i]);

    // priority: both request together, data first then fetch
    bus.fetchReq = 1'b1;
    bus.fetchAddr = 32'h40;
    bus.dataReq = 1'b1;
    bus.dataAddr = 32'h80;
    bus.memReady = 1'b1;
    bus.memReadData = 32'hA5A5_0001;
    wait_req(ok);
    check("prio first grant seen", 64'(ok), 64'(1));
    check("prio data first", 64'({bus.memWrite, bus.memAddr}), 64'({1'b0, 32'h80}));
    tick();
    check("prio data done", 64'({bus.fetchDone, bus.dataDone}), 64'(2'b01));
    bus.dataReq = 1'b0;
    tick();
    wait_req(ok);
    check("prio second grant seen", 64'(ok), 64'(1));
    check("prio fetch second", 64'(bus.memAddr), 64'(32'h40));
    tick();
    check("prio fetch done", 64'({bus.fetchDone, bus.dataDone}), 64'(2'b10));
    quiet();
    tick();
    tick();

    // starvation: continuous loads while fetch waits
    order = "DDDDFDDDDF";
    bus.fetchReq = 1'b1;
    bus.fetchAddr = 32'h200;
    bus.dataReq = 1'b1;
    bus.dataAddr = 32'h100;
    bus.memReady = 1'b1;
    for (int g = 0; g < 10; g++) begin
      wait_req(ok);
      check("starve grant seen", 64'(ok), 64'(1));
      if (!ok) break;
      check("starve grant order", 64'(bus.memAddr), 64'(order[g] == "F" ? 32'h200 : 32'h100));
      tick();
    end
    quiet();
    tick();
    tick();

    // reset while a store waits on memory
    bus.dataReq = 1'b1;
    bus.dataWrite = 1'b1;
    bus.dataByteEnable = 4'hf;
    bus.dataAddr = 32'h55;
    bus.dataWriteData = 32'h0BAD_F00D;
    tick();
    check("rst store granted", 64'(bus.memReq), 64'(1));
    tick();
    #2 reset = 1'b0;
    #1;
    check("rst memReq falls at once", 64'(bus.memReq), 64'(0));
    check("rst clears read data", 64'(bus.dataReadData), 64'(0));
    quiet();
    @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.dataDone || bus.memReq) seen = 1'b1;
    end
    check("rst no done or request", 64'(seen), 64'(0));
    bus.fetchReq = 1'b1;
    bus.fetchAddr = 32'h300;
    bus.memReady = 1'b1;
    bus.memReadData = 32'hABCD_0123;
    tick();
    check("rst fetch granted", 64'({bus.memReq, bus.memAddr}), 64'({1'b1, 32'h300}));
    tick();
    check("rst fetch done", 64'({bus.fetchDone, bus.fetchData}), 64'({1'b1, 32'hABCD_0123}));
    quiet();
    tick();

    // early drop of fetch request
    bus.fetchReq = 1'b1;
    bus.fetchAddr = 32'h400;
    tick();
    check("drop granted", 64'({bus.memReq, bus.memAddr}), 64'({1'b1, 32'h400}));
    bus.fetchReq = 1'b0;
    tick();
    check("drop memReq held", 64'(bus.memReq), 64'(1));
    bus.memReady = 1'b1;
    bus.memReadData = 32'h77;
    tick();
    check("drop done still pulses", 64'({bus.fetchDone, bus.dataDone, bus.fetchData}), 64'({2'b10, 32'h77}));
    bus.memReady = 1'b0;
    tick();
    check("drop idle", 64'({bus.memReq, bus.fetchDone}), 64'(0));
    bus.dataReq = 1'b1;
    bus.dataAddr = 32'h500;
    tick();
    check("drop back to idle", 64'({bus.memReq, bus.memAddr}), 64'({1'b1, 32'h500}));
    bus.memReady = 1'b1;
    tick();
    quiet();
    tick();

    // randomized traffic against the reference model
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    active = 1'b0;
    done_fetch = 1'b0;
    grant_cyc = 0;
    done_at = -1;
    next_arb = 0;
    starve = 0;
    m_fdata = '0;
    m_ddata = '0;
    for (int n = 0; n < 400; n++) begin
      exp_req = active && n > grant_cyc;
      check("rnd memReq", 64'(bus.memReq), 64'(exp_req));
      if (exp_req) check("rnd mem fields", 64'({bus.memWrite, bus.memByteEnable, bus.memAddr}), 64'({m_wr, m_be, m_addr}));
      if (exp_req && m_wr) check("rnd mem wdata", 64'(bus.memWriteData), 64'(m_wdata));
      check("rnd done", 64'({bus.fetchDone, bus.dataDone}), 64'({n == done_at && done_fetch, n == done_at && !done_fetch}));
      check("rnd read data", 64'({bus.fetchData, bus.dataReadData}), 64'({m_fdata, m_ddata}));
      if (!bus.fetchReq || bus.fetchDone || $urandom_range(31) == 0) begin
        bus.fetchReq = ($urandom_range(3) != 0);
        bus.fetchAddr = $urandom;
      end
      if (!bus.dataReq || bus.dataDone || $urandom_range(31) == 0) begin
        bus.dataReq = ($urandom_range(3) != 0);
        bus.dataWrite = 1'($urandom_range(1));
        bus.dataByteEnable = 4'($urandom_range(15));
        bus.dataAddr = $urandom;
        bus.dataWriteData = $urandom;
      end
      bus.memReady = ($urandom_range(2) != 0);
      bus.memReadData = $urandom;
      if (active && n > grant_cyc && bus.memReady) begin
        if (m_fetch) m_fdata = bus.memReadData;
        else if (!m_wr) m_ddata = bus.memReadData;
        done_at = n + 1;
        done_fetch = m_fetch;
        next_arb = n + 2;
        active = 1'b0;
      end else if (!active && n >= next_arb) begin
        gf = bus.fetchReq && (!bus.dataReq || starve == LIMIT);
        if (bus.fetchReq || bus.dataReq) begin
          active = 1'b1;
          grant_cyc = n;
          m_fetch = gf;
          m_addr = gf ? {bus.fetchAddr[31:2], 2'b00} : bus.dataAddr;
          m_wr = !gf && bus.dataWrite;
          m_be = m_wr ? bus.dataByteEnable : 4'hf;
          m_wdata = bus.dataWriteData;
        end
        starve = (gf || !bus.fetchReq) ? 0 : (starve < LIMIT ? starve + 1 : LIMIT);
      end
      tick();
    end
    quiet();
    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
